// File: rtl/perc_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perc_acc: streaming signed vector accumulator with shift-and-saturate     |
// | result stage on a registered valid/ready output port.                     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module perc_acc #(
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 8,
    parameter int          OUT_W  = 16,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     out_trunc
);

    localparam int ACC_W = DATA_W + CNT_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     valid_q;
    logic signed [OUT_W-1:0]  data_q;
    logic                     sat_q;
    logic [CNT_W-1:0]         ocnt_q;
    logic                     trunc_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  scaled_d;
    logic [CNT_W-1:0]         cnt_d;
    logic                     term_d;
    logic signed [OUT_W-1:0]  data_d;
    logic                     sat_d;

    always_comb begin
        sum_d    = acc_q + {{CNT_W{in_data[DATA_W-1]}}, in_data};
        scaled_d = sum_d >>> SHIFT;
        cnt_d    = cnt_q + CNT_ONE;
        // Counter reaching all-ones closes the vector even without in_last.
        term_d   = in_last | (&cnt_d);
        data_d   = scaled_d[OUT_W-1:0];
        sat_d    = 1'b0;
        if (scaled_d > SAT_MAX) begin
            data_d = SAT_MAX[OUT_W-1:0];
            sat_d  = 1'b1;
        end else if (scaled_d < SAT_MIN) begin
            data_d = SAT_MIN[OUT_W-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            ocnt_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        if (term_d) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            data_q  <= data_d;
                            sat_q   <= sat_d;
                            ocnt_q  <= cnt_d;
                            trunc_q <= ~in_last;
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            acc_q <= sum_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign out_cnt   = ocnt_q;
    assign out_trunc = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_perc_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_perc_acc: drives SHIFT=0 and SHIFT=2 instances with one stream and     |
// | compares both against an arithmetic reference. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module tb_perc_acc;

    localparam int MAXC = 255;

    logic               clk = 1'b0;
    logic               reset_;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               in_last;
    logic               out_ready;

    logic               rdy_a, vld_a, sat_a, trc_a;
    logic signed [15:0] dat_a;
    logic [7:0]         cnt_a;
    logic               rdy_b, vld_b, sat_b, trc_b;
    logic signed [15:0] dat_b;
    logic [7:0]         cnt_b;

    perc_acc #(.DATA_W(32), .CNT_W(8), .OUT_W(16), .SHIFT(0)) u_dut_a (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_a),
        .out_ready(out_ready), .out_data(dat_a), .out_sat(sat_a),
        .out_cnt(cnt_a), .out_trunc(trc_a));

    perc_acc #(.DATA_W(32), .CNT_W(8), .OUT_W(16), .SHIFT(2)) u_dut_b (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_b),
        .out_ready(out_ready), .out_data(dat_b), .out_sat(sat_b),
        .out_cnt(cnt_b), .out_trunc(trc_b));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: running sum and count, plus the pending result.
    longint acc_m;
    int     cnt_m;
    bit     hold_m;
    longint exp_d0, exp_d2, exp_cnt;
    bit     exp_s0, exp_s2, exp_trc;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // floor(s / 2^sh) followed by clamping into 16-bit signed range.
    function automatic longint scale_sat(input longint s, input int sh, output bit sat);
        longint d, q;
        d = longint'(1) << sh;
        q = (s >= 0) ? s / d : -((-s + d - 1) / d);
        sat = 1'b0;
        if (q > 32767)  begin q = 32767;  sat = 1'b1; end
        if (q < -32768) begin q = -32768; sat = 1'b1; end
        return q;
    endfunction

    task automatic model_accept(input int d, input bit last);
        acc_m += longint'(d);
        cnt_m++;
        if (last || cnt_m == MAXC) begin
            exp_d0  = scale_sat(acc_m, 0, exp_s0);
            exp_d2  = scale_sat(acc_m, 2, exp_s2);
            exp_cnt = cnt_m;
            exp_trc = !last;
            acc_m   = 0;
            cnt_m   = 0;
            hold_m  = 1'b1;
        end
    endtask

    task automatic check_state();
        check_val("a_in_ready", rdy_a, !hold_m);
        check_val("b_in_ready", rdy_b, !hold_m);
        check_val("a_out_valid", vld_a, hold_m);
        check_val("b_out_valid", vld_b, hold_m);
        if (hold_m) begin
            check_val("a_out_data", dat_a, exp_d0);
            check_val("b_out_data", dat_b, exp_d2);
            check_val("a_out_sat", sat_a, exp_s0);
            check_val("b_out_sat", sat_b, exp_s2);
            check_val("a_out_cnt", cnt_a, exp_cnt);
            check_val("b_out_cnt", cnt_b, exp_cnt);
            check_val("a_out_trunc", trc_a, exp_trc);
            check_val("b_out_trunc", trc_b, exp_trc);
        end
    endtask

    // Called at a negedge; leaves in_valid asserted for back-to-back beats.
    task automatic beat(input int d, input bit last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        if (!hold_m) model_accept(d, last);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        hold_m = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_   = 1'b0;
        @(posedge clk);
        acc_m  = 0;
        cnt_m  = 0;
        hold_m = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        check_val("rst_a_valid", vld_a, 0);
        check_val("rst_b_valid", vld_b, 0);
        check_val("rst_a_data", dat_a, 0);
        check_val("rst_b_data", dat_b, 0);
        check_val("rst_a_sat", sat_a, 0);
        check_val("rst_a_cnt", cnt_a, 0);
        check_val("rst_a_trunc", trc_a, 0);
        check_val("rst_a_ready", rdy_a, 1);
        check_val("rst_b_ready", rdy_b, 1);
    endtask

    initial begin
        reset_ = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        acc_m = 0; cnt_m = 0; hold_m = 1'b0;
        exp_d0 = 0; exp_d2 = 0; exp_cnt = 0; exp_s0 = 0; exp_s2 = 0; exp_trc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Basic three-beat vector
        beat(5, 0); beat(-2, 0); beat(10, 1);
        check_val("t1_data", dat_a, 13);
        release_out();

        // Saturation in both directions and a wide sum
        beat(30000, 0); beat(30000, 1); release_out();
        beat(-40000, 1); release_out();
        beat(32'h7fffffff, 0); beat(32'h7fffffff, 1); release_out();

        // Backpressure with an ignored beat during HOLD
        beat(1, 0); beat(2, 1);
        check_val("t3_data", dat_a, 3);
        repeat (4) idle();
        beat(99, 1);
        release_out();
        beat(4, 1); release_out();

        // Forced termination at maximum length
        for (int i = 0; i < MAXC; i++) beat(1, 0);
        check_val("t4_trunc", trc_a, 1);
        release_out();
        beat(7, 1); release_out();

        // Reset mid-vector and during HOLD
        beat(100, 0); beat(200, 0);
        do_reset();
        beat(7, 1); release_out();
        beat(3, 1);
        do_reset();
        beat(9, 1); release_out();

        // Rounding toward -inf on the shifted instance
        beat(-5, 1);
        check_val("t6_neg", dat_b, -2);
        release_out();
        beat(6, 0); beat(7, 1);
        check_val("t6_pos", dat_b, 3);
        release_out();

        // Randomized vectors, gaps and backpressure
        for (int v = 0; v < 60; v++) begin
            int len, mode, d;
            len  = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0:       d = $urandom_range(0, 400) - 200;
                    1:       d = int'($urandom());
                    default: d = $urandom_range(0, 80000) - 40000;
                endcase
                beat(d, k == len - 1);
                if ($urandom_range(0, 3) == 0 && k != len - 1) idle();
            end
            repeat ($urandom_range(0, 3)) idle();
            release_out();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
